// File: rtl/image_memory_burst_port.sv
// rtl/image_memory_burst_port.sv - image store with burst read engine and write-priority load port
// Reads are issued only while FIFO occupancy plus the outstanding read leaves room, so no beat is ever dropped.

module image_memory_burst_port_fifo #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic [2:0]   count
);

   logic [W-1:0] mem_q [4];
   logic [1:0]   wptr_q;
   logic [1:0]   rptr_q;
   logic [2:0]   count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 2'd1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 2'd1;
         end
         count_q <= count_q + {2'b00, push} - {2'b00, pop};
      end
   end

   assign pop_data = mem_q[rptr_q];
   assign count    = count_q;

endmodule

module image_memory_burst_port #(
   parameter int IMG_W     = 512,
   parameter int IMG_H     = 512,
   parameter int PIX_W     = 8,
   parameter int BURST_MAX = 16,
   localparam int DEPTH    = IMG_W * IMG_H,
   localparam int AW       = $clog2(DEPTH),
   localparam int LW       = $clog2(BURST_MAX)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [LW-1:0]    cmd_len,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [PIX_W-1:0] rd_data,
   output logic             rd_last,
   output logic             cmd_err,
   output logic             busy,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data
);

   localparam logic [0:0]    S_IDLE    = 1'b0;
   localparam logic [0:0]    S_BURST   = 1'b1;
   localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [PIX_W-1:0] mem [DEPTH];
   logic [PIX_W-1:0] mem_rdata_q;

   logic [0:0]    state_q,  state_d;
   logic [AW-1:0] addr_q,   addr_d;
   logic [LW-1:0] len_q,    len_d;
   logic [LW:0]   issued_q, issued_d;
   logic [LW:0]   popped_q, popped_d;
   logic          cmd_err_q, cmd_err_d;
   logic          inflight_q;
   logic          inflight_last_q;

   logic [LW:0]    len_ext;
   logic           issue;
   logic           pop;
   logic           cmd_fire;
   logic           addr_ok;
   logic           burst_done;
   logic [2:0]     fifo_count;
   logic [PIX_W:0] fifo_out;

   assign len_ext    = {1'b0, len_q};
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign addr_ok    = {1'b0, cmd_addr} < DEPTH_X;
   assign pop        = rd_valid && rd_ready;
   assign burst_done = pop && (popped_q == len_ext);
   assign issue      = (state_q == S_BURST) && (issued_q <= len_ext) && !we
                       && ((fifo_count + {2'b00, inflight_q}) < 3'd4);

   // Write wins the single port; issue already excludes we.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (issue) begin
         mem_rdata_q <= mem[addr_q];
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      issued_d  = issued_q;
      popped_d  = popped_q;
      cmd_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               if (addr_ok) begin
                  state_d  = S_BURST;
                  addr_d   = cmd_addr;
                  len_d    = cmd_len;
                  issued_d = '0;
                  popped_d = '0;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         default: begin
            if (issue) begin
               issued_d = issued_q + (LW + 1)'(1);
               addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
            end
            if (pop) begin
               popped_d = popped_q + (LW + 1)'(1);
            end
            if (burst_done) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         len_q           <= '0;
         issued_q        <= '0;
         popped_q        <= '0;
         cmd_err_q       <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         len_q           <= len_d;
         issued_q        <= issued_d;
         popped_q        <= popped_d;
         cmd_err_q       <= cmd_err_d;
         inflight_q      <= issue;
         inflight_last_q <= (issued_q == len_ext);
      end
   end

   image_memory_burst_port_fifo #(
      .W(PIX_W + 1)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (inflight_q),
      .push_data({inflight_last_q, mem_rdata_q}),
      .pop      (pop),
      .pop_data (fifo_out),
      .count    (fifo_count)
   );

   // Outputs are gated by occupancy so they read as zero whenever no beat is held.
   assign rd_valid  = (fifo_count != 3'd0);
   assign rd_data   = rd_valid ? fifo_out[PIX_W-1:0] : '0;
   assign rd_last   = rd_valid && fifo_out[PIX_W];
   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q == S_BURST);
   assign cmd_err   = cmd_err_q;

endmodule
